// File: rtl/arch_map_recovery.sv
// Committed (retirement) map with in-order bundle retire and free-tag return.
// On flush, the committed map is streamed to the front-end RAT in beats.
module arch_map_recovery #(
  parameter int N_ARCH_REG    = 32,
  parameter int N_PHYS_REG    = 64,
  parameter int WAYS          = 2,
  parameter int RESTORE_LANES = 8,
  parameter int PHYS_BITS     = $clog2(N_PHYS_REG),
  parameter int AR_BITS       = $clog2(N_ARCH_REG)
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [WAYS-1:0]                    retire_valid,
  input  logic [WAYS*AR_BITS-1:0]            retire_ar_idx,
  input  logic [WAYS*PHYS_BITS-1:0]          retire_t_idx,
  output logic [WAYS-1:0]                    free_valid,
  output logic [WAYS*PHYS_BITS-1:0]          free_idx,
  input  logic                               flush_req,
  output logic                               restore_valid,
  input  logic                               restore_ready,
  output logic [AR_BITS-1:0]                 restore_base,
  output logic [RESTORE_LANES*PHYS_BITS-1:0] restore_data,
  output logic                               restore_done,
  output logic                               busy,
  output logic [N_ARCH_REG*PHYS_BITS-1:0]    arch_maptable
);

  localparam int N_BEATS  = N_ARCH_REG / RESTORE_LANES;
  localparam int PTR_BITS = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RESTORE,
    DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [PTR_BITS-1:0]      ptr_q, ptr_d;
  logic [PHYS_BITS-1:0]     map_q [N_ARCH_REG];
  logic [PHYS_BITS-1:0]     map_d [N_ARCH_REG];
  logic [WAYS-1:0]          fv_d;
  logic [WAYS*PHYS_BITS-1:0] fi_d;
  logic                     idle;
  logic                     last_beat;

  assign idle      = (state_q == IDLE);
  assign last_beat = (ptr_q == PTR_BITS'(N_BEATS - 1));

  // Lane k sees the map with lanes 0..k-1 already applied.
  always_comb begin
    logic [AR_BITS-1:0] ar;
    ar    = '0;
    map_d = map_q;
    fv_d  = '0;
    fi_d  = '0;
    for (int k = 0; k < WAYS; k++) begin
      if (idle && retire_valid[k]) begin
        ar = retire_ar_idx[k*AR_BITS +: AR_BITS];
        fv_d[k] = 1'b1;
        fi_d[k*PHYS_BITS +: PHYS_BITS] = map_d[ar];
        map_d[ar] = retire_t_idx[k*PHYS_BITS +: PHYS_BITS];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d = RESTORE;
          ptr_d   = '0;
        end
      end
      RESTORE: begin
        if (restore_ready) begin
          if (last_beat) state_d = DONE;
          else           ptr_d   = ptr_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // The map is frozen outside IDLE, so it doubles as the flush snapshot.
  always_comb begin
    restore_valid = (state_q == RESTORE);
    restore_done  = (state_q == DONE);
    busy          = !idle;
    restore_base  = '0;
    restore_data  = '0;
    if (restore_valid) begin
      restore_base = AR_BITS'(ptr_q) * AR_BITS'(RESTORE_LANES);
      for (int l = 0; l < RESTORE_LANES; l++) begin
        restore_data[l*PHYS_BITS +: PHYS_BITS] =
          map_q[restore_base + AR_BITS'(l)];
      end
    end
  end

  for (genvar i = 0; i < N_ARCH_REG; i++) begin : g_flat
    assign arch_maptable[i*PHYS_BITS +: PHYS_BITS] = map_q[i];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      free_valid <= '0;
      free_idx   <= '0;
      for (int i = 0; i < N_ARCH_REG; i++) begin
        map_q[i] <= PHYS_BITS'(i);
      end
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      free_valid <= fv_d;
      free_idx   <= fi_d;
      map_q      <= map_d;
    end
  end

endmodule
